pulse_to_level: RTL

PULSE_TO_LEVEL -- requirements
Module: pulse_to_level

---
 rtl/pulse_to_level.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/pulse_to_level.sv
// ---------------------------------------------------------------------------
// pulse_to_level
//
// Stretches single-cycle request pulses into level pulses of programmable
// length. Each served pulse drives `level` high for max(hold_len,1) cycles.
//
// Default build (queuing mode):
//   Pulses arriving while a hold is active are counted in `pending`. Each one
//   is served after a one-cycle low GAP. The pending count saturates; a pulse
//   that cannot be counted is dropped and sets the sticky `overflow` flag.
//
// Optional build, macro PULSE_TO_LEVEL_RETRIGGER_EN (retrigger mode):
//   A pulse during a hold restarts the hold from the current hold_len. There
//   is no queue: `pending` and `overflow` are tied to zero and GAP is never
//   entered.
//
// Parameters:
//   HOLD_W   width of hold_len and of the internal hold counter
//   PEND_W   width of the pending-pulse counter
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst       asynchronous, active-low reset
//   pulse     single-cycle request, sampled every rising edge
//   hold_len  level length in cycles (0 behaves as 1), sampled on HOLD entry
//   clr       synchronous clear of the overflow flag
//   level     registered stretched output, high only in HOLD
//   busy      high whenever the FSM is not in IDLE (decoded from state)
//   pending   number of queued pulses not yet served
//   overflow  sticky flag, set when a pulse is dropped
// ---------------------------------------------------------------------------
module pulse_to_level #(
  parameter int unsigned HOLD_W = 8,
  parameter int unsigned PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              clr,
  output logic              level,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q,   cnt_d;
  logic              level_q, level_d;

  // Hold length to load on every entry to HOLD; a zero request still gives
  // one cycle of level.
  logic [HOLD_W-1:0] hold_load;
  // Current cycle is the final cycle of the active hold.
  logic              last_hold;

  assign hold_load = (hold_len == '0) ? HOLD_ONE : hold_len;
  assign last_hold = (state_q == HOLD) && (cnt_q <= HOLD_ONE);

`ifdef PULSE_TO_LEVEL_RETRIGGER_EN

  // -------------------------------------------------------------------------
  // Retrigger mode: no queue, so the pending/overflow path does not exist.
  // -------------------------------------------------------------------------
  logic unused_clr;
  assign unused_clr = clr;

  // Next-state / counter logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pulse) begin
          state_d = HOLD;
          cnt_d   = hold_load;
        end
      end
      HOLD: begin
        if (pulse) begin
          // Restart the hold; level stays high without a break.
          cnt_d = hold_load;
        end else if (last_hold) begin
          state_d = IDLE;
          cnt_d   = cnt_q - HOLD_ONE;
        end else begin
          cnt_d = cnt_q - HOLD_ONE;
        end
      end
      default: begin
        // GAP is unreachable in this mode; recover to IDLE.
        state_d = IDLE;
      end
    endcase
  end

  assign pending  = '0;
  assign overflow = 1'b0;

`else

  // -------------------------------------------------------------------------
  // Queuing mode: pending counter and sticky overflow flag.
  // -------------------------------------------------------------------------
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q,  ovf_d;

  logic queue_req;  // a pulse that must be queued (hold or gap active)
  logic serve;      // GAP moves to HOLD, consuming one queued pulse
  logic drop;       // pulse arrived with the queue full and nothing leaving

  assign queue_req = pulse && (state_q != IDLE);
  assign serve     = (state_q == GAP) && (pend_q != '0);

  // Pending counter and overflow flag.
  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
    if (serve && queue_req) begin
      // One pulse leaves and one arrives: count is unchanged, nothing lost.
      pend_d = pend_q;
    end else if (serve) begin
      pend_d = pend_q - PEND_ONE;
    end else if (queue_req) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end

    // A drop in the same cycle as clr keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Next-state / counter logic. The exit from HOLD looks at pend_d so that a
  // pulse on the final hold cycle is already counted and forces GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pulse) begin
          state_d = HOLD;
          cnt_d   = hold_load;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - HOLD_ONE;
        if (last_hold) begin
          state_d = (pend_d != '0) ? GAP : IDLE;
        end
      end
      GAP: begin
        state_d = HOLD;
        cnt_d   = hold_load;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pending  = pend_q;
  assign overflow = ovf_q;

`endif

  // -------------------------------------------------------------------------
  // Output logic: level is registered from the next state so it lines up
  // with HOLD exactly; busy is a pure decode of the current state.
  // -------------------------------------------------------------------------
  always_comb begin
    level_d = (state_d == HOLD);
  end

  assign busy  = (state_q != IDLE);
  assign level = level_q;

  // -------------------------------------------------------------------------
  // State register.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering; the asynchronous reset
  // clears every flop here, including the counter, so no stale hold survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule
